// File: rtl/axis_out.sv
// AXI-Stream master for FIR results: buffers samples in a small FIFO, marks the
// final beat of the programmed run with sm_tlast and pulses ap_done afterwards.
module axis_out #(
  parameter int pDATA_WIDTH = 32,
  parameter int pLEN_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic [pDATA_WIDTH-1:0] fir_data,
  input  logic                   fir_valid,
  output logic                   out_ready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   busy,
  output logic                   ap_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [pLEN_WIDTH-1:0]  len_q, len_d;
  logic [pLEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [pLEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic is_run;
  logic push;
  logic pop;

  // Full blocks writes even when a pop happens in the same cycle (no bypass).
  assign is_run    = (state_q == S_RUN);
  assign out_ready = is_run && (count_q != CNT_W'(FIFO_DEPTH)) && (in_cnt_q != len_q);
  assign sm_tvalid = is_run && (count_q != '0);
  assign sm_tdata  = sm_tvalid ? mem_q[rd_ptr_q] : '0;
  assign sm_tlast  = sm_tvalid && (out_cnt_q == len_q - pLEN_WIDTH'(1));
  assign push      = fir_valid && out_ready;
  assign pop       = sm_tvalid && sm_tready;
  assign busy      = (state_q != S_IDLE);
  assign ap_done   = (state_q == S_DONE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d     = data_length;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (data_length != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          in_cnt_d = in_cnt_q + pLEN_WIDTH'(1);
        end
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          out_cnt_d = out_cnt_q + pLEN_WIDTH'(1);
        end
        unique case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
        if (pop && sm_tlast) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are never
  // observable because sm_tdata is forced to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fir_data;
  end

endmodule

// File: doc/axis_out.md
Name: axis_out

Overview:
- AXI-Stream master at the output of the FIR datapath.
- Accepts FIR results over a valid/ready strobe interface and buffers them in a small FIFO.
- Drives the stream to the testbench/host and asserts tlast on the final sample of the programmed length.
- Pulses ap_done once the last beat has been accepted downstream.

Parameters:
- pDATA_WIDTH, 32, width of the sample data.
- pLEN_WIDTH, 16, width of the data_length value and of the internal beat counters.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  one-cycle start pulse from the control block.
- data_length  in  pLEN_WIDTH  number of output samples for this run; sampled on ap_start.
- fir_data  in  pDATA_WIDTH  FIR result.
- fir_valid  in  1  fir_data is valid this cycle.
- out_ready  out  1  block can accept fir_data this cycle.
- sm_tvalid  out  1  AXIS master valid.
- sm_tdata  out  pDATA_WIDTH  AXIS master data.
- sm_tlast  out  1  marks the final beat of the run.
- sm_tready  in  1  AXIS slave ready.
- busy  out  1  high in RUN and DONE states.
- ap_done  out  1  one-cycle pulse after the last beat handshake.

Behaviour:
- Reset: state=IDLE; FIFO empty (wr_ptr=rd_ptr=0, count=0); len_reg=0; in_cnt=0; out_cnt=0.
  - Outputs after reset: out_ready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0, busy=0, ap_done=0.
  - Reset asserted mid-run aborts immediately: all buffered data is discarded and no ap_done is produced.
- FSM IDLE:
  - On ap_start: latch data_length into len_reg; clear in_cnt and out_cnt.
  - If data_length != 0, go to RUN; if data_length == 0, go to DONE.
  - fir_valid is ignored in IDLE.
- FSM RUN:
  - Input side: out_ready = (count != FIFO_DEPTH) && (in_cnt != len_reg).
  - When fir_valid && out_ready: write fir_data at wr_ptr, wr_ptr++, in_cnt++.
  - Output side: sm_tvalid = (count != 0); sm_tdata = FIFO entry at rd_ptr, or 0 when empty.
  - sm_tlast = sm_tvalid && (out_cnt == len_reg-1).
  - When sm_tvalid && sm_tready: rd_ptr++, out_cnt++.
  - Last-beat handshake (sm_tlast && sm_tready): go to DONE.
  - ap_start is ignored while in RUN.
- FSM DONE: ap_done=1 for exactly one cycle; next state is IDLE. ap_start in DONE is ignored.
- Latency: a sample written at edge N is visible on sm_tvalid/sm_tdata after edge N, i.e. one cycle later. There is no combinational path from fir_valid to sm_tvalid.
- AXIS rule: while sm_tvalid=1 and sm_tready=0, sm_tdata and sm_tlast hold stable, and sm_tvalid stays high.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - When full, out_ready=0 even if a pop occurs in the same cycle; there is no full-bypass.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits wide, ranging 0..FIFO_DEPTH.
- Over-supply: after in_cnt reaches len_reg, out_ready=0 and extra fir_valid is ignored.
- Counters are pLEN_WIDTH wide. A length of 2^pLEN_WIDTH-1 is supported; no wrap occurs within a run.
- busy = (state==RUN) || (state==DONE).

Test Plan:
- Basic run: ap_start with data_length=3; fir_data 0x11, 0x22, 0x33 on consecutive cycles; sm_tready=1 -> three beats 0x11/0x22/0x33; sm_tlast only on 0x33; ap_done pulses the cycle after that beat; then back to IDLE.
- Backpressure: length=8, FIFO_DEPTH=4, sm_tready=0 -> out_ready drops after 4 writes and sm_tdata holds the first sample. Then sm_tready=1 -> all 8 values arrive in order, tlast on the 8th.
- Simultaneous push/pop: FIFO full and sm_tready=1 with fir_valid=1 -> out_ready=0 that cycle. The next cycle, with count=3, push and pop together keep count at 3 and data order is intact.
- Zero and unit lengths: data_length=0 -> no sm_tvalid, ap_done one cycle after ap_start. data_length=1 -> a single beat with sm_tlast=1.
- Over-supply: length=2 with fir_valid held high for 5 cycles -> only 2 samples are accepted; out_ready=0 afterward.
- Reset mid-run: rst_n low after 2 of 5 beats -> all outputs return to 0 immediately. A following run with length=2 emits only the new data and no stale entries.
